// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot/debug loader.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_BUS,
      ST_RESP
   } state_t;

   localparam logic [7:0] CMD_WRITE    = 8'h01;
   localparam logic [7:0] CMD_READ     = 8'h02;
   localparam logic [7:0] CMD_RUN      = 8'h03;
   localparam logic [7:0] RSP_ACK      = 8'h06;
   localparam logic [7:0] RSP_NAK      = 8'h15;
   localparam logic [7:0] SYNC_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_loader_txser.sv
// Response serialiser: sends one status byte, optionally followed by a
// little-endian 32-bit word, over a valid/ready byte handshake.
module uart_loader_txser (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        long_resp,
   input  logic [7:0]  first,
   input  logic [31:0] word,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done
);

   logic [31:0] shreg;
   logic [2:0]  rem;

   // done marks the handshake of the final byte of the response
   assign done = tx_valid && tx_ready && (rem == 3'd0);

   // load on start; after every accepted byte present the next one, LSB first
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         shreg    <= 32'h0;
         rem      <= 3'd0;
      end else if (start) begin
         tx_data  <= first;
         tx_valid <= 1'b1;
         shreg    <= word;
         rem      <= long_resp ? 3'd4 : 3'd0;
      end else if (tx_valid && tx_ready) begin
         if (rem == 3'd0) begin
            tx_valid <= 1'b0;
         end else begin
            tx_data <= shreg[7:0];
            shreg   <= {8'h00, shreg[31:8]};
            rem     <= rem - 3'd1;
         end
      end
   end

endmodule

// File: rtl/uart_loader.sv
// Packet parser and bus master for the UART loader. Holds the CPU in reset
// until a RUN packet has been acknowledged.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int         C_TIMEOUT_CYCLES = 5000000,
   parameter logic [7:0] C_SYNC           = SYNC_DEFAULT,
   parameter bit         C_HOLD_AT_RESET  = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   output logic        bus_valid,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic        cpu_hold
);

   localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(C_TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  cmd;
   logic [1:0]  idx;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [TW-1:0] tcnt;

   logic       cmd_known;
   logic       tx_start;
   logic       tx_long;
   logic [7:0] tx_first;
   logic       tx_done;

   assign cmd_known = (rx_data == CMD_WRITE) || (rx_data == CMD_READ) ||
                      (rx_data == CMD_RUN);

   // response kick-off is combinational so the first byte appears the cycle
   // after the bus handshake / RUN address completion / bad command
   always_comb begin
      tx_start = 1'b0;
      tx_long  = 1'b0;
      tx_first = RSP_ACK;
      case (state)
         ST_CMD: if (rx_valid && !cmd_known) begin
            tx_start = 1'b1;
            tx_first = RSP_NAK;
         end
         ST_ADDR: if (rx_valid && idx == 2'd3 && cmd == CMD_RUN)
            tx_start = 1'b1;
         ST_BUS: if (bus_ready) begin
            tx_start = 1'b1;
            tx_long  = (bus_wstrb == 4'h0);
         end
         default: ;
      endcase
   end

   uart_loader_txser u_txser (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (tx_start),
      .long_resp (tx_long),
      .first     (tx_first),
      .word      (bus_rdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .done      (tx_done)
   );

   // packet FSM, inter-byte timeout, bus request and CPU hold
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cmd       <= 8'h00;
         idx       <= 2'd0;
         addr      <= 32'h0;
         wdata     <= 32'h0;
         tcnt      <= '0;
         bus_valid <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wdata <= 32'h0;
         bus_wstrb <= 4'h0;
         cpu_hold  <= C_HOLD_AT_RESET;
      end else begin
         case (state)
            ST_IDLE: begin
               tcnt <= '0;
               if (rx_valid && rx_data == C_SYNC)
                  state <= ST_CMD;
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
               if (rx_valid) begin
                  // a byte arriving on the expiry cycle still counts
                  tcnt <= '0;
                  case (state)
                     ST_CMD: begin
                        cmd   <= rx_data;
                        idx   <= 2'd0;
                        state <= cmd_known ? ST_ADDR : ST_RESP;
                     end
                     ST_ADDR: begin
                        addr[8*idx +: 8] <= rx_data;
                        idx              <= idx + 2'd1;
                        if (idx == 2'd3) begin
                           if (cmd == CMD_WRITE) begin
                              state <= ST_DATA;
                           end else if (cmd == CMD_READ) begin
                              state     <= ST_BUS;
                              bus_valid <= 1'b1;
                              bus_addr  <= {rx_data, addr[23:2], 2'b00};
                              bus_wstrb <= 4'h0;
                           end else begin
                              state <= ST_RESP;
                           end
                        end
                     end
                     default: begin
                        wdata[8*idx +: 8] <= rx_data;
                        idx               <= idx + 2'd1;
                        if (idx == 2'd3) begin
                           state     <= ST_BUS;
                           bus_valid <= 1'b1;
                           bus_addr  <= {addr[31:2], 2'b00};
                           bus_wdata <= {rx_data, wdata[23:0]};
                           bus_wstrb <= 4'hF;
                        end
                     end
                  endcase
               end else if (tcnt == T_LAST) begin
                  tcnt  <= '0;
                  state <= ST_IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_BUS: begin
               tcnt <= '0;
               if (bus_ready) begin
                  bus_valid <= 1'b0;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               tcnt <= '0;
               if (tx_done) begin
                  state <= ST_IDLE;
                  if (cmd == CMD_RUN)
                     cpu_hold <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
